axis_packet_sink: RTL and testbench

AXIS_PACKET_SINK -- requirements
Module: axis_packet_sink

---
 rtl/axis_packet_sink.sv | 159 +++++++++++++++
 tb/tb_axis_packet_sink.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_sink.sv
// axis_packet_sink: AXI-stream packet sink with random back-pressure, a word
// buffer, keep/overflow checks and an optional signed checksum.
// Ports: clk, rst (async high); s_valid/s_ready/s_last/s_keep/s_data beat in;
// pkt_done, pkt_words, keep_err, ovf_err, pkt_sum status; pkt_ack release;
// rd_addr -> rd_data registered buffer read.
// Option: define AXIS_SINK_CHECKSUM_EN to enable the pkt_sum accumulator.
module axis_packet_sink #(
  parameter int WORD_W = 8,
  parameter int BUS_W = 8,
  parameter int PROB_READY = 20,
  parameter int DEPTH = 256,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int WPB = BUS_W / WORD_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  output logic s_ready,
  input  logic s_last,
  input  logic [WPB-1:0] s_keep,
  input  logic [WPB*WORD_W-1:0] s_data,
  output logic pkt_done,
  output logic [CW-1:0] pkt_words,
  output logic keep_err,
  output logic ovf_err,
  input  logic pkt_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [31:0] pkt_sum
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [15:0] lfsr_mod;
  logic rnd;
  logic accept;
  logic bad_keep;
  logic drop;
  logic [31:0] pos;
  logic [CW-1:0] words_nxt;
  logic [WPB-1:0] wr_en;
  logic [AW-1:0] wr_addr [WPB];
  logic [WORD_W-1:0] mem [DEPTH];

  // Galois LFSR, taps 16,14,13,11
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign lfsr_mod = lfsr % 16'd100;
  assign rnd = {16'd0, lfsr_mod} < 32'(PROB_READY);

  assign accept = s_valid && s_ready && (state != DONE);

  // keep must look like 0..01..1; non-last beats must keep every lane
  assign bad_keep = ((s_keep & (s_keep + WPB'(1))) != '0)
                 || (!s_last && !(&s_keep));

  // kept lanes pack at consecutive addresses; words past DEPTH drop
  always_comb begin
    wr_en = '0;
    drop = 1'b0;
    pos = 32'(pkt_words);
    for (int i = 0; i < WPB; i++) begin
      wr_addr[i] = '0;
      if (s_keep[i]) begin
        if (pos < 32'(DEPTH)) begin
          wr_en[i] = accept;
          wr_addr[i] = pos[AW-1:0];
        end else begin
          drop = 1'b1;
        end
        pos = pos + 32'd1;
      end
    end
    words_nxt = (pos > 32'(DEPTH)) ? CW'(DEPTH) : pos[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s_ready <= 1'b0;
      pkt_done <= 1'b0;
      pkt_words <= '0;
      keep_err <= 1'b0;
      ovf_err <= 1'b0;
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_nxt;
      // no offer while in DONE nor on the cycle right after the last beat
      s_ready <= (state != DONE) && !(accept && s_last) && rnd;
      unique case (state)
        IDLE, RECV: begin
          if (accept) begin
            pkt_words <= words_nxt;
            if (bad_keep) keep_err <= 1'b1;
            if (drop) ovf_err <= 1'b1;
            if (s_last) begin
              state <= DONE;
              pkt_done <= 1'b1;
            end else begin
              state <= RECV;
            end
          end
        end
        DONE: begin
          if (pkt_ack) begin
            state <= IDLE;
            pkt_done <= 1'b0;
            pkt_words <= '0;
            keep_err <= 1'b0;
            ovf_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_SINK_CHECKSUM_EN
  logic [31:0] sum_add;

  always_comb begin
    sum_add = '0;
    for (int i = 0; i < WPB; i++) begin
      if (wr_en[i]) begin
        sum_add = sum_add
          + 32'(signed'(s_data[i*WORD_W +: WORD_W]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_sum <= '0;
    end else if (state == DONE && pkt_ack) begin
      pkt_sum <= '0;
    end else if (accept) begin
      pkt_sum <= pkt_sum + sum_add;
    end
  end
`else
  assign pkt_sum = '0;
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < WPB; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= s_data[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_axis_packet_sink.sv
// tb_axis_packet_sink: three sink instances (wide bus, tiny buffer,
// random back-pressure) checked against a queue-based packet model.
module tb_axis_packet_sink;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tmo = 0;

  // A: 8-bit words, 4 lanes, always ready, 256 deep
  logic a_valid, a_last, a_ack, a_ready, a_done, a_kerr, a_ovf;
  logic [3:0] a_keep;
  logic [31:0] a_data, a_sum;
  logic [7:0] a_rd_addr, a_rd;
  logic [8:0] a_words;

  // B: single lane, always ready, 4 deep
  logic b_valid, b_last, b_ack, b_ready, b_done, b_kerr, b_ovf;
  logic [0:0] b_keep;
  logic [7:0] b_data, b_rd;
  logic [31:0] b_sum;
  logic [1:0] b_rd_addr;
  logic [2:0] b_words;

  // C: 2 lanes, 20% ready
  logic c_valid, c_last, c_ack, c_ready, c_done, c_kerr, c_ovf;
  logic [1:0] c_keep;
  logic [15:0] c_data;
  logic [31:0] c_sum;
  logic [7:0] c_rd_addr, c_rd;
  logic [8:0] c_words;

  axis_packet_sink #(.WORD_W(8), .BUS_W(32), .PROB_READY(100),
    .DEPTH(256)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready),
    .s_last(a_last), .s_keep(a_keep), .s_data(a_data),
    .pkt_done(a_done), .pkt_words(a_words), .keep_err(a_kerr),
    .ovf_err(a_ovf), .pkt_ack(a_ack), .rd_addr(a_rd_addr),
    .rd_data(a_rd), .pkt_sum(a_sum));

  axis_packet_sink #(.WORD_W(8), .BUS_W(8), .PROB_READY(100),
    .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready),
    .s_last(b_last), .s_keep(b_keep), .s_data(b_data),
    .pkt_done(b_done), .pkt_words(b_words), .keep_err(b_kerr),
    .ovf_err(b_ovf), .pkt_ack(b_ack), .rd_addr(b_rd_addr),
    .rd_data(b_rd), .pkt_sum(b_sum));

  axis_packet_sink #(.WORD_W(8), .BUS_W(16), .PROB_READY(20),
    .DEPTH(256)) dut_c (
    .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c_ready),
    .s_last(c_last), .s_keep(c_keep), .s_data(c_data),
    .pkt_done(c_done), .pkt_words(c_words), .keep_err(c_kerr),
    .ovf_err(c_ovf), .pkt_ack(c_ack), .rd_addr(c_rd_addr),
    .rd_data(c_rd), .pkt_sum(c_sum));

  // ready statistics for C, sampled once per cycle
  bit stat_en = 1'b0;
  int nd_cyc = 0;
  int rdy_cyc = 0;
  int rdy_in_done = 0;
  always @(negedge clk) begin
    if (stat_en) begin
      if (c_done) begin
        if (c_ready) rdy_in_done++;
      end else begin
        nd_cyc++;
        if (c_ready) rdy_cyc++;
      end
    end
  end

  function automatic logic [31:0] exp_sum(input int s);
`ifdef AXIS_SINK_CHECKSUM_EN
    return 32'(s);
`else
    return 32'd0 + 32'(s - s);
`endif
  endfunction

  task automatic send_a(input logic [31:0] d, input logic [3:0] k,
                        input logic l);
    int n = 0;
    a_valid = 1'b1; a_data = d; a_keep = k; a_last = l;
    while (!a_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) tmo++;
    @(negedge clk);
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int n = 0;
    b_valid = 1'b1; b_data = d; b_keep = 1'b1; b_last = l;
    while (!b_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) tmo++;
    @(negedge clk);
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic ack_a();
    a_ack = 1'b1;
    @(negedge clk);
    a_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (a_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready got=%b want=0", a_ready); end
    total++;
    if (a_done !== 1'b0) begin bad++;
      $display("FAIL reset_done got=%b want=0", a_done); end
    total++;
    if (a_words !== 9'd0) begin bad++;
      $display("FAIL reset_words got=%0d want=0", a_words); end
    total++;
    if (a_kerr !== 1'b0 || a_ovf !== 1'b0) begin bad++;
      $display("FAIL reset_errs got=%b%b want=00", a_kerr, a_ovf); end
    total++;
    if (a_sum !== 32'd0) begin bad++;
      $display("FAIL reset_sum got=%0d want=0", a_sum); end
    total++;
    if (a_rd !== 8'd0) begin bad++;
      $display("FAIL reset_rd got=%h want=00", a_rd); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp [9];
    for (int i = 0; i < 8; i++) exp[i] = 8'(i + 1);
    exp[8] = 8'h0A;
    send_a(32'h04030201, 4'hF, 1'b0);
    send_a(32'h08070605, 4'hF, 1'b0);
    send_a(32'h0000000A, 4'h1, 1'b1);
    total++;
    if (a_done !== 1'b1) begin bad++;
      $display("FAIL basic_done got=%b want=1", a_done); end
    total++;
    if (a_words !== 9'd9) begin bad++;
      $display("FAIL basic_words got=%0d want=9", a_words); end
    total++;
    if (a_sum !== exp_sum(46)) begin bad++;
      $display("FAIL basic_sum got=%0d want=%0d", a_sum, exp_sum(46)); end
    total++;
    if (a_kerr !== 1'b0 || a_ovf !== 1'b0) begin bad++;
      $display("FAIL basic_errs got=%b%b want=00", a_kerr, a_ovf); end
    for (int i = 0; i < 9; i++) begin
      a_rd_addr = 8'(i);
      @(negedge clk);
      total++;
      if (a_rd !== exp[i]) begin bad++;
        $display("FAIL basic_rd[%0d] got=%h want=%h", i, a_rd, exp[i]); end
    end
    ack_a();
    total++;
    if (a_done !== 1'b0 || a_words !== 9'd0) begin bad++;
      $display("FAIL basic_ack got=%b/%0d want=0/0", a_done, a_words); end
  endtask

  task automatic test_keep_err();
    logic [31:0] d;
    d = $urandom;
    send_a(d, 4'b0101, 1'b0);
    send_a($urandom, 4'b0000, 1'b1);
    total++;
    if (a_done !== 1'b1 || a_ready !== 1'b0) begin bad++;
      $display("FAIL kerr_done got=%b/%b want=1/0", a_done, a_ready); end
    total++;
    if (a_words !== 9'd2) begin bad++;
      $display("FAIL kerr_words got=%0d want=2", a_words); end
    total++;
    if (a_kerr !== 1'b1) begin bad++;
      $display("FAIL kerr_flag got=%b want=1", a_kerr); end
    a_rd_addr = 8'd0;
    @(negedge clk);
    total++;
    if (a_rd !== d[7:0]) begin bad++;
      $display("FAIL kerr_rd0 got=%h want=%h", a_rd, d[7:0]); end
    a_rd_addr = 8'd1;
    @(negedge clk);
    total++;
    if (a_rd !== d[23:16]) begin bad++;
      $display("FAIL kerr_rd1 got=%h want=%h", a_rd, d[23:16]); end
    ack_a();
    total++;
    if (a_kerr !== 1'b0 || a_done !== 1'b0 || a_ready !== 1'b0) begin
      bad++;
      $display("FAIL kerr_ack got=%b%b%b want=000", a_kerr, a_done,
               a_ready); end
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1) begin bad++;
      $display("FAIL kerr_ready_back got=%b want=1", a_ready); end
  endtask

  task automatic test_random_a();
    logic [7:0] q [$];
    logic [3:0] k;
    logic [31:0] d;
    logic l, kerr, gap;
    int nb, s, n;
    for (int p = 0; p < 15; p++) begin
      q.delete(); kerr = 1'b0; s = 0;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        l = (b == nb - 1);
        d = $urandom;
        if ($urandom_range(0, 3) == 0) k = 4'($urandom);
        else if (l) begin
          n = $urandom_range(0, 4);
          k = 4'((1 << n) - 1);
        end else k = 4'hF;
        if (!l && k != 4'hF) kerr = 1'b1;
        gap = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!k[i]) gap = 1'b1;
          else begin
            if (gap) kerr = 1'b1;
            q.push_back(d[8*i +: 8]);
            s += int'($signed(d[8*i +: 8]));
          end
        end
        send_a(d, k, l);
      end
      total++;
      if (a_done !== 1'b1) begin bad++;
        $display("FAIL rnd_a_done p=%0d got=%b want=1", p, a_done); end
      total++;
      if (a_words !== 9'(q.size())) begin bad++;
        $display("FAIL rnd_a_words p=%0d got=%0d want=%0d", p, a_words,
                 q.size()); end
      total++;
      if (a_kerr !== kerr || a_ovf !== 1'b0) begin bad++;
        $display("FAIL rnd_a_errs p=%0d got=%b%b want=%b0", p, a_kerr,
                 a_ovf, kerr); end
      total++;
      if (a_sum !== exp_sum(s)) begin bad++;
        $display("FAIL rnd_a_sum p=%0d got=%0d want=%0d", p, a_sum,
                 exp_sum(s)); end
      for (int i = 0; i < q.size(); i++) begin
        a_rd_addr = 8'(i);
        @(negedge clk);
        total++;
        if (a_rd !== q[i]) begin bad++;
          $display("FAIL rnd_a_rd p=%0d a=%0d got=%h want=%h", p, i,
                   a_rd, q[i]); end
      end
      ack_a();
      total++;
      if (a_done !== 1'b0 || a_words !== 9'd0 || a_sum !== 32'd0) begin
        bad++;
        $display("FAIL rnd_a_ack p=%0d got=%b/%0d/%0d want=0/0/0", p,
                 a_done, a_words, a_sum); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) send_b(8'(i), i == 6);
    total++;
    if (b_done !== 1'b1 || b_words !== 3'd4) begin bad++;
      $display("FAIL ovf_words got=%b/%0d want=1/4", b_done, b_words); end
    total++;
    if (b_ovf !== 1'b1 || b_kerr !== 1'b0) begin bad++;
      $display("FAIL ovf_flags got=%b%b want=10", b_ovf, b_kerr); end
    total++;
    if (b_sum !== exp_sum(10)) begin bad++;
      $display("FAIL ovf_sum got=%0d want=%0d", b_sum, exp_sum(10)); end
    for (int i = 0; i < 4; i++) begin
      b_rd_addr = 2'(i);
      @(negedge clk);
      total++;
      if (b_rd !== 8'(i + 1)) begin bad++;
        $display("FAIL ovf_rd[%0d] got=%h want=%h", i, b_rd, 8'(i + 1));
      end
    end
    b_ack = 1'b1;
    @(negedge clk);
    b_ack = 1'b0;
    total++;
    if (b_ovf !== 1'b0 || b_words !== 3'd0) begin bad++;
      $display("FAIL ovf_ack got=%b/%0d want=0/0", b_ovf, b_words); end
  endtask

  task automatic test_duty();
    logic [7:0] q [$];
    logic [1:0] k;
    logic [15:0] d;
    int left, nb, n;
    left = 1000;
    stat_en = 1'b1;
    while (left > 0) begin
      q.delete();
      nb = $urandom_range(1, 40);
      if (nb > left) nb = left;
      for (int b = 0; b < nb; b++) begin
        d = 16'($urandom);
        if (b == nb - 1) begin
          n = $urandom_range(0, 2);
          k = 2'((1 << n) - 1);
        end else k = 2'b11;
        for (int i = 0; i < 2; i++)
          if (k[i]) q.push_back(d[8*i +: 8]);
        c_valid = 1'b1; c_data = d; c_keep = k; c_last = (b == nb - 1);
        n = 0;
        while (!c_ready && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) tmo++;
        @(negedge clk);
        c_valid = 1'b0; c_last = 1'b0;
      end
      left -= nb;
      total++;
      if (c_done !== 1'b1 || c_words !== 9'(q.size())) begin bad++;
        $display("FAIL duty_pkt got=%b/%0d want=1/%0d", c_done, c_words,
                 q.size()); end
      total++;
      if (c_kerr !== 1'b0 || c_ovf !== 1'b0) begin bad++;
        $display("FAIL duty_errs got=%b%b want=00", c_kerr, c_ovf); end
      for (int i = 0; i < q.size(); i++) begin
        c_rd_addr = 8'(i);
        @(negedge clk);
        total++;
        if (c_rd !== q[i]) begin bad++;
          $display("FAIL duty_rd a=%0d got=%h want=%h", i, c_rd, q[i]);
        end
      end
      c_ack = 1'b1;
      @(negedge clk);
      c_ack = 1'b0;
    end
    stat_en = 1'b0;
    total++;
    if (rdy_cyc * 100 < 15 * nd_cyc || rdy_cyc * 100 > 25 * nd_cyc) begin
      bad++;
      $display("FAIL duty_ratio got=%0d/%0d want=15..25 pct", rdy_cyc,
               nd_cyc); end
    total++;
    if (rdy_in_done !== 0) begin bad++;
      $display("FAIL duty_done_ready got=%0d want=0", rdy_in_done); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int s;
    for (int i = 0; i < 3; i++) send_a($urandom, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (a_words !== 9'd0 || a_ready !== 1'b0) begin bad++;
      $display("FAIL rstmid_clear got=%0d/%b want=0/0", a_words, a_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    d = $urandom;
    s = int'($signed(d[7:0])) + int'($signed(d[15:8]));
    send_a(d, 4'b0011, 1'b1);
    total++;
    if (a_done !== 1'b1 || a_words !== 9'd2) begin bad++;
      $display("FAIL rstmid_words got=%b/%0d want=1/2", a_done, a_words);
    end
    total++;
    if (a_kerr !== 1'b0 || a_ovf !== 1'b0) begin bad++;
      $display("FAIL rstmid_errs got=%b%b want=00", a_kerr, a_ovf); end
    total++;
    if (a_sum !== exp_sum(s)) begin bad++;
      $display("FAIL rstmid_sum got=%0d want=%0d", a_sum, exp_sum(s)); end
    for (int i = 0; i < 2; i++) begin
      a_rd_addr = 8'(i);
      @(negedge clk);
      total++;
      if (a_rd !== d[8*i +: 8]) begin bad++;
        $display("FAIL rstmid_rd[%0d] got=%h want=%h", i, a_rd,
                 d[8*i +: 8]); end
    end
    ack_a();
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_last = 0; a_ack = 0; a_keep = '0; a_data = '0;
    a_rd_addr = '0;
    b_valid = 0; b_last = 0; b_ack = 0; b_keep = '0; b_data = '0;
    b_rd_addr = '0;
    c_valid = 0; c_last = 0; c_ack = 0; c_keep = '0; c_data = '0;
    c_rd_addr = '0;
    test_reset();
    test_basic();
    test_keep_err();
    test_random_a();
    test_overflow();
    test_duty();
    test_reset_mid();
    total++;
    if (tmo !== 0) begin bad++;
      $display("FAIL handshake_timeouts got=%0d want=0", tmo); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
